// File: rtl/vga_vram_arbiter_if.sv
// vga_vram_arbiter_if: CPU access handshake into the character-RAM arbiter
interface vga_vram_arbiter_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [8:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_ack;
  modport master(output cpu_req, cpu_we, cpu_addr, cpu_wdata, input cpu_rdata, cpu_ack);
  modport slave(input cpu_req, cpu_we, cpu_addr, cpu_wdata, output cpu_rdata, cpu_ack);
endinterface

// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares one 512x8 char RAM among display prefetch, CPU and fill/scroll engine
module vga_vram_arbiter #(
  parameter int DISP_SLOT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           x_hi,
  input  logic [4:0]           x_lo,
  input  logic [4:0]           y_hi,
  input  logic [5:0]           y_lo,
  output logic [7:0]           disp_char,
  output logic                 disp_valid,
  vga_vram_arbiter_if.slave    cpu,
  input  logic                 cmd_start,
  input  logic                 cmd_scroll,
  input  logic [7:0]           fill_char,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [8:0]           mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata
);
  typedef enum logic [1:0] {IDLE, SC_RD, SC_WR, FILL} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_CPU, OWN_ENG} own_t;
  state_t     state, state_n;
  own_t       own;
  logic [8:0] ptr, ptr_n;
  logic [7:0] fill_q, fill_n, hold, disp_q, rdata_q;
  logic       done_n, disp_slot, cpu_issue, eng_issue;
  logic       unused_y_lo;
  assign unused_y_lo = ^y_lo;
  assign disp_slot = x_lo == 5'(DISP_SLOT) && !y_hi[4] && (x_hi <= 6'd30 || x_hi == 6'd40);
  assign busy      = state != IDLE;
  assign cpu_issue = !disp_slot && cpu.cpu_req && !busy && !cpu.cpu_ack;
  assign eng_issue = !disp_slot && !cpu_issue && busy;
  assign mem_en    = disp_slot || cpu_issue || eng_issue;
  assign mem_we    = cpu_issue ? cpu.cpu_we : eng_issue && state != SC_RD;
  assign mem_addr  = disp_slot ? {y_hi[3:0], x_hi == 6'd40 ? 5'd0 : x_hi[4:0] + 5'd1} :
                     cpu_issue ? cpu.cpu_addr :
                     state == SC_RD ? ptr + 9'd32 : ptr;
  // A write issued right after its read must take the byte straight off the RAM bus
  assign mem_wdata = cpu_issue ? cpu.cpu_wdata :
                     state == FILL ? fill_q :
                     own == OWN_ENG ? mem_rdata : hold;
  assign disp_valid    = own == OWN_DISP;
  assign disp_char     = own == OWN_DISP ? mem_rdata : disp_q;
  assign cpu.cpu_rdata = own == OWN_CPU ? mem_rdata : rdata_q;
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    fill_n  = fill_q;
    done_n  = 1'b0;
    case (state)
      IDLE: if (cmd_start) begin
        state_n = cmd_scroll ? SC_RD : FILL;
        ptr_n   = '0;
        fill_n  = fill_char;
      end
      SC_RD: if (eng_issue) state_n = SC_WR;
      SC_WR: if (eng_issue) begin
        state_n = ptr == 9'd479 ? FILL : SC_RD;
        ptr_n   = ptr + 9'd1;
      end
      default: if (eng_issue) begin
        state_n = ptr == 9'd511 ? IDLE : FILL;
        ptr_n   = ptr + 9'd1;
        done_n  = ptr == 9'd511;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      own         <= OWN_NONE;
      ptr         <= '0;
      fill_q      <= '0;
      hold        <= '0;
      disp_q      <= '0;
      rdata_q     <= '0;
      cpu.cpu_ack <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      fill_q      <= fill_n;
      done        <= done_n;
      cpu.cpu_ack <= cpu_issue;
      own         <= disp_slot ? OWN_DISP :
                     cpu_issue && !cpu.cpu_we ? OWN_CPU :
                     eng_issue && state == SC_RD ? OWN_ENG : OWN_NONE;
      if (own == OWN_DISP) disp_q <= mem_rdata;
      if (own == OWN_CPU) rdata_q <= mem_rdata;
      if (own == OWN_ENG) hold <= mem_rdata;
    end
  end
endmodule
